// File: rtl/shift_fifo_pkg.sv
// ---------------------------------------------------------------------------
// shift_fifo_pkg : shared constants and helpers for the shift-register FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_level_flags.sv
// ---------------------------------------------------------------------------
// fifo_level_flags : combinational occupancy flags decoded from a count value
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_level_flags
  import shift_fifo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = cnt_w(DEPTH)
) (
  input  logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

endmodule

`default_nettype wire

// File: rtl/shift_fifo_flags.sv
// ---------------------------------------------------------------------------
// shift_fifo_flags : shift-register FIFO, head always in mem[0], with level,
//                    threshold and sticky error flags.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_fifo_flags
  import shift_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int FWFT     = FIFO_STD,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      read,
  input  logic                      clr_err,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 2 || DEPTH > 16) begin : g_chk_depth
    $error("shift_fifo_flags: DEPTH must be 2..16");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
    $error("shift_fifo_flags: AF_LEVEL must be 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
    $error("shift_fifo_flags: AE_LEVEL must be 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;
  logic [CW-1:0]    wr_idx;

  fifo_level_flags #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_flags (
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  assign wr_ok  = write & ~full;
  assign rd_ok  = read & ~empty;
  // On a concurrent read the queue shifts down, so the tail slot moves too.
  assign wr_idx = rd_ok ? (count - CW'(1)) : count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else begin
      if (rd_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && wr_idx == CW'(i)) mem[i] <= data_in;
      end
      if (wr_ok && !rd_ok)      count <= count + CW'(1);
      else if (rd_ok && !wr_ok) count <= count - CW'(1);
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out  = mem[0];
    assign valid_out = ~empty;
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end else begin
        valid_out <= rd_ok;
        if (rd_ok) data_out <= mem[0];
      end
    end
  end

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (write & full)  | (overflow  & ~clr_err);
      underflow <= (read  & empty) | (underflow & ~clr_err);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_fifo_flags.sv
// ---------------------------------------------------------------------------
// tb_shift_fifo_flags : standard and FWFT instances against a queue model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_fifo_flags;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] s_data, f_data;
  logic       s_valid, f_valid;
  logic [2:0] s_count, f_count;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovf, m_unf;

  always #5 clk = ~clk;

  shift_fifo_flags #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_std (
    .clk(clk), .rst_n(rst_n), .write(write), .data_in(data_in), .read(read),
    .clr_err(clr_err), .data_out(s_data), .valid_out(s_valid), .count(s_count),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .overflow(s_ovf), .underflow(s_unf)
  );

  shift_fifo_flags #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .write(write), .data_in(data_in), .read(read),
    .clr_err(clr_err), .data_out(f_data), .valid_out(f_valid), .count(f_count),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":s_count"}, 32'(s_count), 32'(n));
    chk({tag, ":f_count"}, 32'(f_count), 32'(n));
    chk({tag, ":full"},    {30'd0, s_full,  f_full},  {30'd0, n == DEPTH, n == DEPTH});
    chk({tag, ":empty"},   {30'd0, s_empty, f_empty}, {30'd0, n == 0, n == 0});
    chk({tag, ":afull"},   {30'd0, s_af,    f_af},    {30'd0, n >= 3, n >= 3});
    chk({tag, ":aempty"},  {30'd0, s_ae,    f_ae},    {30'd0, n <= 1, n <= 1});
    chk({tag, ":ovf"},     {30'd0, s_ovf,   f_ovf},   {30'd0, m_ovf, m_ovf});
    chk({tag, ":unf"},     {30'd0, s_unf,   f_unf},   {30'd0, m_unf, m_unf});
    chk({tag, ":s_valid"}, 32'(s_valid), 32'(m_valid));
    chk({tag, ":s_data"},  32'(s_data),  32'(m_data));
    chk({tag, ":f_valid"}, 32'(f_valid), 32'(n != 0));
    if (n != 0) chk({tag, ":f_data"}, 32'(f_data), 32'(q[0]));
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 time unit later.
  task automatic step(input string tag, input logic w, input logic [7:0] d,
                      input logic r, input logic c);
    bit was_full, was_empty;
    @(negedge clk);
    write = w; data_in = d; read = r; clr_err = c;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (r && !was_empty) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (w && !was_full) q.push_back(d);
    m_ovf = (w && was_full)  || (m_ovf && !c);
    m_unf = (r && was_empty) || (m_unf && !c);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("fill1", 1, 8'h11, 0, 0);
    step("fill2", 1, 8'h22, 0, 0);
    step("fill3", 1, 8'h33, 0, 0);
    step("fill4", 1, 8'h44, 0, 0);
    step("ovf",   1, 8'h55, 0, 0);
    step("clr_vs_set", 1, 8'h66, 0, 1);
    step("clr_ovf",    0, 8'h00, 0, 1);

    step("drain1", 0, 8'h00, 1, 0);
    step("drain2", 0, 8'h00, 1, 0);
    step("drain3", 0, 8'h00, 1, 0);
    step("drain4", 0, 8'h00, 1, 0);
    step("unf",    0, 8'h00, 1, 0);
    step("clr_unf", 0, 8'h00, 0, 1);
    step("idle",   0, 8'h00, 0, 0);

    step("fwft_wr", 1, 8'hA5, 0, 0);
    step("fwft_hold", 0, 8'h00, 0, 0);
    step("fwft_rd", 0, 8'h00, 1, 0);

    step("rw_pre1", 1, 8'h11, 0, 0);
    step("rw_pre2", 1, 8'h22, 0, 0);
    step("rw1", 1, 8'h33, 1, 0);
    step("rw2", 1, 8'h44, 1, 0);
    step("rw3", 1, 8'h55, 1, 0);
    step("rw_d1", 0, 8'h00, 1, 0);
    step("rw_d2", 0, 8'h00, 1, 0);
    step("rw_empty", 1, 8'h77, 1, 0);
    step("rw_one", 1, 8'h88, 1, 0);
    step("clr2", 0, 8'h00, 0, 1);

    step("pre_rst1", 1, 8'h99, 0, 0);
    step("pre_rst2", 1, 8'h9A, 0, 0);
    @(negedge clk);
    write = 1'b0; read = 1'b0; clr_err = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1, 8'hC3, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_fifo_flags.md
# shift_fifo_flags

Parametrised shift-register FIFO and the next generation of the team's small synchronous FIFOs. It adds a selectable read mode (standard or first-word-fall-through), a level output, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It sits between a producer and a consumer in a single clock domain, as a short elastic buffer (DEPTH 2–16).

## Interface
- `WIDTH`, 8, data width in bits (≥1)
- `DEPTH`, 4, number of entries (2–16)
- `FWFT`, 0, read mode: 0 = standard (data one cycle after read), 1 = first-word-fall-through
- `AF_LEVEL`, DEPTH-1, `almost_full` asserts when `count >= AF_LEVEL` (1..DEPTH)
- `AE_LEVEL`, 1, `almost_empty` asserts when `count <= AE_LEVEL` (0..DEPTH-1)

Ports (one clock; reset is asynchronous and active-low, named `clk` and `rst_n`):
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `write`  in  1  write request
- `data_in`  in  WIDTH  write data
- `read`  in  1  read request
- `clr_err`  in  1  synchronous clear of the sticky error flags
- `data_out`  out  WIDTH  read data
- `valid_out`  out  1  `data_out` holds a valid word
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `full`, `empty`  out  1  `count == DEPTH` / `count == 0`
- `almost_full`, `almost_empty`  out  1  threshold flags
- `overflow`, `underflow`  out  1  sticky error flags

## Operation
- Storage is `mem[0..DEPTH-1]`. The head (oldest word) is always in `mem[0]`; valid entries are `mem[0..count-1]`.
- `wr_ok = write & ~full`; `rd_ok = read & ~empty`. A write while full is never accepted, even with a concurrent read.
- `wr_ok & ~rd_ok`: `mem[count] <= data_in`; `count` increments.
- `rd_ok & ~wr_ok`: every entry shifts down (`mem[i] <= mem[i+1]`); `count` decrements.
- `rd_ok & wr_ok`: entries shift down and `mem[count-1] <= data_in`; `count` is unchanged. With `count == 1`, `data_in` lands in `mem[0]`.
- Empty with read and write together: only the write is accepted, and `underflow` sets.
- Vacated slots are not cleared; their contents are don't-care.
- `FWFT=1`: `data_out = mem[0]` and `valid_out = ~empty`, both combinational from registers. A read consumes the presented word.
- `FWFT=0`: on `rd_ok`, `data_out <= mem[0]` and `valid_out <= 1`. Without `rd_ok`, `valid_out <= 0` and `data_out` holds its value.
- `overflow` sets on `write & full`; `underflow` sets on `read & empty`. Both clear on `clr_err`; if set and clear occur in the same cycle, set wins.
- All flags are decoded from the `count` register only. There is no combinational path from `write`, `read` or `data_in` to any flag.
- `count` arithmetic is $clog2(DEPTH)+1 bits and never wraps: the guards keep it in 0..DEPTH.

## Timing
- Reset values (async, active-low): `count=0`, `mem` all zero, `data_out=0`, `valid_out=0`, `empty=1`, `full=0`, `almost_empty=1` (`AE_LEVEL ≥ 0`), `almost_full=0`, `overflow=0`, `underflow=0`.
- Reset asserted mid-operation discards all contents immediately. The first accepted write takes place at the first rising edge after `rst_n` deasserts.
- Write-to-read latency:
  - FWFT: a word written into an empty FIFO appears on `data_out` with `valid_out=1` one cycle after the write edge.
  - Standard: one further cycle after the `read` edge.
- Flags and `count` update on the same edge as the accepted operation.
- Throughput is one write and one read per cycle in steady state (`0 < count < DEPTH`).

## Structure
- Package `shift_fifo_pkg` holds:
  - `function automatic int cnt_w(int depth)` returning `$clog2(depth)+1`
  - `localparam` mode constants `FIFO_STD=0`, `FIFO_FWFT=1`
- Sub-module `fifo_level_flags`: takes `count` plus the DEPTH/AF/AE parameters and produces `full`, `empty`, `almost_full` and `almost_empty`. It is purely combinational and reusable by other FIFOs.
- Parameter checks are elaboration-time assertions:
  - `DEPTH` in 2..16
  - `AF_LEVEL` in 1..DEPTH
  - `AE_LEVEL` in 0..DEPTH-1

## Test plan
All scenarios use WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
- **Reset:** assert `rst_n=0` mid-stream with `count=3` → next sample shows `count=0`, `empty=1`, `almost_empty=1`, `valid_out=0`, errors 0.
- **Fill:** write 0x11,0x22,0x33,0x44 → `almost_full` from `count=3`, `full` at 4. A fifth write of 0x55 sets `overflow`, and `count` stays 4.
- **Drain (FWFT=0):** read ×4 → `data_out` shows 0x11,0x22,0x33,0x44 with `valid_out=1`, each one cycle after its read. A fifth read sets `underflow`.
- **FWFT=1:** a single write of 0xA5 into empty → next cycle `data_out=0xA5`, `valid_out=1` with no read asserted.
- **Simultaneous read/write:** at `count=2` holding [0x11,0x22], write 0x33 and read together for 3 cycles → `count` stays 2 and words exit in order 0x11,0x22,0x33. Read+write at `count=0` → `count=1`, `underflow=1`.
- **Error flags:** with `overflow=1`, assert `clr_err` together with `write` while full → `overflow` stays 1. Then `clr_err` alone → `overflow=0`.
